uart8_rx_controller: RTL
========================

Name: uart8_rx_controller

Overview:
- Sequences the 8-bit UART receiver: drives its `en`, captures each received byte on `done` into a small FIFO, and presents bytes downstream on a valid/ready stream.
- Detects receiver `err` pulses, counts them, and holds the receiver disabled for a programmable holdoff before re-arming it.
- Sits between the receiver (16x-oversample baud clock domain) and the consuming logic; runs entirely on that same clock.

Parameters:
- FIFO_DEPTH, 4, number of byte entries; must be a power of 2, minimum 2.
- HOLDOFF_CYCLES, 16, clocks `rx_en` is held low after an error; range 1..255.
- ERR_CNT_W, 8, width of the saturating error counter.

Ports:
- clk  in  1  receiver clock (16x baud).
- rst_n  in  1  asynchronous, active-low reset.
- enable  in  1  software enable for reception.
- flush  in  1  synchronous; empties the FIFO in one cycle.
- clr  in  1  synchronous; clears `overflow` and `err_count`.
- rx_en  out  1  to receiver `en`.
- rx_data  in  8  receiver `out`.
- rx_done  in  1  receiver one-cycle done pulse.
- rx_busy  in  1  receiver busy.
- rx_err  in  1  receiver error pulse.
- m_data  out  8  FIFO head byte.
- m_valid  out  1  FIFO not empty.
- m_ready  in  1  consumer accepts `m_data`.
- level  out  $clog2(FIFO_DEPTH)+1  FIFO occupancy.
- overflow  out  1  sticky; a byte was dropped because the FIFO was full.
- err_count  out  ERR_CNT_W  saturating count of `rx_err` pulses.
- active  out  1  high in RUN while `rx_busy` is high (frame in progress).

Behaviour:
- Reset values: all outputs 0. FSM starts in OFF, FIFO empty, holdoff counter 0.
- `rx_en` is registered; it equals 1 exactly when the state is RUN.
- FSM states and transitions:
  - OFF: go to RUN when `enable`=1.
  - RUN: if `enable`=0, go to OFF. Else if `rx_err`=1, go to RECOVER, load holdoff counter with HOLDOFF_CYCLES-1, and increment `err_count`.
  - RECOVER: `rx_en`=0 and the counter decrements each clock. At 0, go to RUN if `enable`=1, else OFF. `enable`=0 during RECOVER goes to OFF immediately.
  - HALT: exists only without the optional feature (see below).
- Both `enable`=0 and `rx_err`=1 in RUN: `enable` wins, state goes to OFF, and `err_count` still increments.
- Capture:
  - On `rx_done`=1 in RUN, push `rx_data` into the FIFO.
  - `rx_done` in any other state is ignored.
  - Latency: `rx_done` at edge N gives `m_valid`=1 and `m_data`=byte after edge N+1 (first-word fall-through, registered).
- Pop: occurs when `m_valid` && `m_ready`; `m_data` advances on the next edge.
- Full FIFO (`level`=FIFO_DEPTH):
  - Push with no pop: byte dropped, `overflow` set, contents unchanged.
  - Push and pop in the same cycle: both take effect and `level` is unchanged.
- Empty FIFO: `m_ready` is ignored and `m_data` holds its last value.
- Pointers wrap modulo FIFO_DEPTH. `level` is a separate up/down counter.
- `flush`:
  - Read and write pointers and `level` go to 0 on the next edge.
  - A push or pop in the same cycle is discarded.
  - `overflow` is unaffected.
- `clr`: zeroes `overflow` and `err_count`. If a set event coincides with `clr`, the set wins (`overflow`=1, `err_count`=1).
- `err_count` saturates at all-ones and never wraps.
- `rst_n` asserted mid-frame: immediate OFF, `rx_en`=0, FIFO emptied; the partial frame is lost.
- `enable` dropped mid-frame: the receiver is disabled on the next edge, the frame is aborted, and the FIFO is retained.

Optional Feature:
- Macro: UART_RX_CTRL_AUTO_RECOVER_EN.
- Defined: error handling is RECOVER with automatic re-arm, as described above.
- Undefined:
  - `rx_err` in RUN goes to HALT (`rx_en`=0) and increments `err_count`.
  - HALT exits to OFF only when `clr`=1 or `enable`=0. From OFF, normal OFF->RUN rules apply.
  - The holdoff counter and HOLDOFF_CYCLES are unused.

Test Plan:
- Reset, then `enable`=1 -> `rx_en`=1 one edge later. Inject `rx_done` with `rx_data`=0xA5 -> `m_valid`=1, `m_data`=0xA5, `level`=1 one edge later; `m_ready`=1 -> `level`=0.
- Four bytes 0x01..0x04 with `m_ready`=0, then 0x05 -> `level`=4, `overflow`=1, drain order 0x01,0x02,0x03,0x04. Repeat with 0x05 arriving during a pop -> 0x05 is kept as the 4th entry.
- Auto-recover (macro on): `rx_err` pulse in RUN -> `err_count`=1, `rx_en`=0 for exactly 16 clocks, then `rx_en`=1. `rx_done` during RECOVER is not captured.
- Macro off: `rx_err` -> `rx_en` stays 0 for 100 clocks; `clr` -> OFF, then RUN with `err_count`=0.
- Saturation with ERR_CNT_W=2: 5 error pulses -> `err_count`=3. Simultaneous `clr`+`rx_err` -> `err_count`=1.
- `level`=3: `flush` with `m_ready`=1 and `rx_done`=1 in the same cycle -> `level`=0, `m_valid`=0. `rst_n` low mid-frame -> all outputs 0 asynchronously.

Source files
------------

// File: rtl/uart8_rx_controller.sv
// UART8 receive controller: arms the receiver, buffers bytes in a first-word-fall-through FIFO, counts errors.
// Define UART_RX_CTRL_AUTO_RECOVER_EN for timed auto re-arm after rx_err; otherwise an error halts reception.
module uart8_rx_controller #(
   parameter int FIFO_DEPTH     = 4,
   parameter int HOLDOFF_CYCLES = 16,
   parameter int ERR_CNT_W      = 8
) (
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic                          enable,
   input  logic                          flush,
   input  logic                          clr,
   output logic                          rx_en,
   input  logic [7:0]                    rx_data,
   input  logic                          rx_done,
   input  logic                          rx_busy,
   input  logic                          rx_err,
   output logic [7:0]                    m_data,
   output logic                          m_valid,
   input  logic                          m_ready,
   output logic [$clog2(FIFO_DEPTH):0]   level,
   output logic                          overflow,
   output logic [ERR_CNT_W-1:0]          err_count,
   output logic                          active
);
   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int LW = AW + 1;

   if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0 ||
       HOLDOFF_CYCLES < 1 || HOLDOFF_CYCLES > 255) begin : g_bad_params
      $error("uart8_rx_controller: illegal FIFO_DEPTH or HOLDOFF_CYCLES");
   end

`ifdef UART_RX_CTRL_AUTO_RECOVER_EN
   typedef enum logic [1:0] {ST_OFF, ST_RUN, ST_RECOVER} state_t;
   logic [7:0] hold_q, hold_d;
`else
   typedef enum logic [1:0] {ST_OFF, ST_RUN, ST_HALT} state_t;
`endif

   state_t               state_q, state_d;
   logic                 rx_en_q;
   logic                 err_inc;
   logic [ERR_CNT_W-1:0] err_q, err_d;
   logic                 ovf_q, ovf_d, ovf_set;
   logic [7:0]           mem_q [FIFO_DEPTH];
   logic [AW-1:0]        wr_q, wr_d, rd_q, rd_d;
   logic [LW-1:0]        level_q, level_d;
   logic [7:0]           m_data_q, m_data_d;
   logic                 push_req, do_push, do_pop, full;

   always_comb begin
      state_d = state_q;
      err_inc = 1'b0;
`ifdef UART_RX_CTRL_AUTO_RECOVER_EN
      hold_d  = hold_q;
`endif
      case (state_q)
         ST_OFF: if (enable) state_d = ST_RUN;
         ST_RUN: begin
            // An error is counted even when the simultaneous enable drop wins the transition.
            err_inc = rx_err;
            if (!enable) begin
               state_d = ST_OFF;
            end else if (rx_err) begin
`ifdef UART_RX_CTRL_AUTO_RECOVER_EN
               state_d = ST_RECOVER;
               hold_d  = 8'(HOLDOFF_CYCLES - 1);
`else
               state_d = ST_HALT;
`endif
            end
         end
`ifdef UART_RX_CTRL_AUTO_RECOVER_EN
         ST_RECOVER: begin
            if (!enable)            state_d = ST_OFF;
            else if (hold_q == 8'd0) state_d = ST_RUN;
            else                     hold_d  = hold_q - 8'd1;
         end
`else
         ST_HALT: if (clr || !enable) state_d = ST_OFF;
`endif
         default: state_d = ST_OFF;
      endcase
   end

   assign push_req = rx_done && (state_q == ST_RUN);
   assign full     = (level_q == LW'(FIFO_DEPTH));
   assign do_pop   = (level_q != '0) && m_ready && !flush;
   assign do_push  = push_req && (!full || do_pop) && !flush;
   assign ovf_set  = push_req && full && !do_pop && !flush;

   always_comb begin
      wr_d     = wr_q;
      rd_d     = rd_q;
      level_d  = level_q;
      m_data_d = m_data_q;
      if (flush) begin
         wr_d    = '0;
         rd_d    = '0;
         level_d = '0;
      end else begin
         if (do_push) wr_d = wr_q + AW'(1);
         if (do_pop)  rd_d = rd_q + AW'(1);
         level_d = level_q + LW'(do_push) - LW'(do_pop);
         // The head register bypasses the array when the incoming byte becomes the new head.
         if (do_push && (level_q - LW'(do_pop)) == '0) m_data_d = rx_data;
         else if (level_d != '0)                       m_data_d = mem_q[rd_d];
      end
   end

   always_comb begin
      ovf_d = ovf_q;
      if (ovf_set)  ovf_d = 1'b1;
      else if (clr) ovf_d = 1'b0;
      err_d = err_q;
      if (err_inc)  err_d = clr ? ERR_CNT_W'(1) : ((err_q == '1) ? err_q : err_q + ERR_CNT_W'(1));
      else if (clr) err_d = '0;
   end

   always_ff @(posedge clk) begin
      if (do_push) mem_q[wr_q] <= rx_data;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= ST_OFF;
         rx_en_q  <= 1'b0;
         err_q    <= '0;
         ovf_q    <= 1'b0;
         wr_q     <= '0;
         rd_q     <= '0;
         level_q  <= '0;
         m_data_q <= '0;
`ifdef UART_RX_CTRL_AUTO_RECOVER_EN
         hold_q   <= '0;
`endif
      end else begin
         state_q  <= state_d;
         rx_en_q  <= (state_d == ST_RUN);
         err_q    <= err_d;
         ovf_q    <= ovf_d;
         wr_q     <= wr_d;
         rd_q     <= rd_d;
         level_q  <= level_d;
         m_data_q <= m_data_d;
`ifdef UART_RX_CTRL_AUTO_RECOVER_EN
         hold_q   <= hold_d;
`endif
      end
   end

   assign rx_en     = rx_en_q;
   assign m_data    = m_data_q;
   assign m_valid   = (level_q != '0);
   assign level     = level_q;
   assign overflow  = ovf_q;
   assign err_count = err_q;
   assign active    = (state_q == ST_RUN) && rx_busy;
endmodule
